// File: rtl/aska_spi_master_pkg.sv
// aska_spi_master_pkg: shared state encoding, default frame length and sizing helper for the SPI master
package aska_spi_master_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;
  localparam int DEF_FRAME_BITS = 16;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/aska_spi_master_if.sv
// aska_spi_master_if: frame handshake between a frame producer and the SPI master
interface aska_spi_master_if #(parameter int FRAME_BITS = aska_spi_master_pkg::DEF_FRAME_BITS);
  logic tx_valid;
  logic tx_ready;
  logic [FRAME_BITS-1:0] tx_data;
  logic busy;
  logic done;
  modport master (output tx_valid, tx_data, input tx_ready, busy, done);
  modport slave (input tx_valid, tx_data, output tx_ready, busy, done);
endinterface

// File: rtl/aska_spi_phase_cnt.sv
// aska_spi_phase_cnt: loadable saturating down-counter with zero flag for timed FSM phases
module aska_spi_phase_cnt #(parameter int W = 2) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/aska_spi_master.sv
// aska_spi_master: mode-0 SPI master sending one MSB-first CS-framed frame per handshake
module aska_spi_master
  import aska_spi_master_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP        = 2
) (
  input  logic               clk,
  input  logic               reset,
  aska_spi_master_if.slave   tx,
  output logic               SPI_CS,
  output logic               SPI_Clk,
  output logic               SPI_MOSI
);
  localparam int PW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, GAP) + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  state_e state, state_nx;
  logic [FRAME_BITS-2:0] sreg, sreg_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic cs_nx, sck_nx, mosi_nx, rdy, rdy_nx, done, done_nx, ld, zero;
  logic [PW-1:0] ld_val;
  aska_spi_phase_cnt #(.W(PW)) u_phase (
    .clk(clk), .reset(reset), .load(ld), .load_val(ld_val), .zero(zero)
  );
  assign tx.tx_ready = rdy;
  assign tx.busy = ~rdy;
  assign tx.done = done;
  // MSB goes straight to MOSI on accept, so sreg only holds the remaining bits
  always_comb begin
    state_nx = state;
    sreg_nx = sreg;
    bcnt_nx = bcnt;
    cs_nx = SPI_CS;
    sck_nx = SPI_Clk;
    mosi_nx = SPI_MOSI;
    rdy_nx = rdy;
    done_nx = 1'b0;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      S_IDLE: if (tx.tx_valid) begin
        state_nx = S_SETUP;
        sreg_nx = tx.tx_data[FRAME_BITS-2:0];
        cs_nx = 1'b0;
        mosi_nx = tx.tx_data[FRAME_BITS-1];
        rdy_nx = 1'b0;
        ld = 1'b1;
        ld_val = PW'(CS_SETUP - 1);
      end
      S_SETUP: if (zero) begin
        state_nx = S_SHIFT;
        bcnt_nx = BW'(FRAME_BITS - 1);
        ld = 1'b1;
        ld_val = PW'(CLK_DIV - 1);
      end
      S_SHIFT: if (zero) begin
        ld = 1'b1;
        ld_val = PW'(CLK_DIV - 1);
        sck_nx = ~SPI_Clk;
        if (SPI_Clk) begin
          if (bcnt == '0) begin
            state_nx = S_HOLD;
            ld_val = PW'(CS_HOLD - 1);
          end else begin
            bcnt_nx = bcnt - 1'b1;
            sreg_nx = sreg << 1;
            mosi_nx = sreg[FRAME_BITS-2];
          end
        end
      end
      S_HOLD: if (zero) begin
        state_nx = S_GAP;
        cs_nx = 1'b1;
        mosi_nx = 1'b0;
        done_nx = 1'b1;
        ld = 1'b1;
        ld_val = PW'(GAP - 1);
      end
      S_GAP: if (zero) begin
        state_nx = S_IDLE;
        rdy_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      sreg <= '0;
      bcnt <= '0;
      SPI_CS <= 1'b1;
      SPI_Clk <= 1'b0;
      SPI_MOSI <= 1'b0;
      rdy <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      bcnt <= bcnt_nx;
      SPI_CS <= cs_nx;
      SPI_Clk <= sck_nx;
      SPI_MOSI <= mosi_nx;
      rdy <= rdy_nx;
      done <= done_nx;
    end
endmodule

// File: tb/tb_aska_spi_master.sv
// tb_aska_spi_master: directed vectors against a mode-0 slave model for default and fast configurations
module tb_aska_spi_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aska_spi_master_if #(.FRAME_BITS(16)) aif();
  aska_spi_master_if #(.FRAME_BITS(8)) bif();
  wire [1:0] cs_w, sck_w, mosi_w;
  wire [1:0] done_w = {bif.done, aif.done};

  aska_spi_master dut_a (
    .clk(clk), .reset(reset), .tx(aif),
    .SPI_CS(cs_w[0]), .SPI_Clk(sck_w[0]), .SPI_MOSI(mosi_w[0])
  );
  aska_spi_master #(.FRAME_BITS(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP(1)) dut_b (
    .clk(clk), .reset(reset), .tx(bif),
    .SPI_CS(cs_w[1]), .SPI_Clk(sck_w[1]), .SPI_MOSI(mosi_w[1])
  );

  logic [1:0] p_cs = 2'b11, p_sck = 2'b00, p_mosi = 2'b00;
  logic [15:0] cap [2], last_fr [2], prev_fr [2];
  int nb [2], tog [2], lo [2], hi [2], last_hi [2], bits_at [2], lo_at [2], tog_at [2], nfr [2], ndone [2];
  int v_mosi, v_done, cyc, pass_cnt, total;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model: samples MOSI on SCK rise inside CS-low, logs frame stats on CS rise
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!cs_w[d] && p_cs[d]) begin
        last_hi[d] = hi[d]; lo[d] = 0; nb[d] = 0; tog[d] = 0; cap[d] = '0;
      end
      if (cs_w[d] && !p_cs[d]) begin
        prev_fr[d] = last_fr[d]; last_fr[d] = cap[d]; bits_at[d] = nb[d];
        lo_at[d] = lo[d]; tog_at[d] = tog[d]; nfr[d]++; hi[d] = 0;
      end
      if (cs_w[d]) hi[d]++; else lo[d]++;
      if (!cs_w[d] && sck_w[d] && !p_sck[d]) begin
        cap[d] = {cap[d][14:0], mosi_w[d]}; nb[d]++;
      end
      if (!cs_w[d] && !p_cs[d] && mosi_w[d] != p_mosi[d]) tog[d]++;
      if (sck_w[d] && mosi_w[d] != p_mosi[d]) v_mosi++;
      if (done_w[d]) begin
        ndone[d]++;
        if (!(cs_w[d] && !p_cs[d])) v_done++;
      end
    end
    p_cs = cs_w; p_sck = sck_w; p_mosi = mosi_w;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic rdy(input int d);
    return d == 0 ? aif.tx_ready : bif.tx_ready;
  endfunction

  task automatic drive(input int d, input logic v, input logic [15:0] data);
    if (d == 0) begin aif.tx_valid = v; aif.tx_data = data; end
    else begin bif.tx_valid = v; bif.tx_data = data[7:0]; end
  endtask

  task automatic wait_rdy(input int d);
    int n = 0;
    while (!rdy(d) && n < 3000) begin tick; n++; end
    if (n >= 3000) begin total++; $display("FAIL wait_rdy: timeout on dut %0d", d); end
  endtask

  // returns in the first cycle after the accepting edge, with tx_valid dropped
  task automatic start(input int d, input logic [15:0] data);
    drive(d, 1'b1, data);
    wait_rdy(d);
    @(posedge clk);
    tick;
    drive(d, 1'b0, 16'h0);
  endtask

  task automatic send(input int d, input logic [15:0] data, output int lat);
    start(d, data);
    lat = 1;
    while (!rdy(d) && lat < 3000) begin tick; lat++; end
  endtask

  typedef struct {
    int d;
    logic [15:0] data;
    int bits;
    int cs_low;
    int lat;
    int tog;
  } vec_t;
  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, n0, dn, t0;
    vt[0] = '{0, 16'hA5C3, 16, 132, 135, 8};
    vt[1] = '{0, 16'h0000, 16, 132, 135, 0};
    vt[2] = '{0, 16'hFFFF, 16, 132, 135, 0};
    vt[3] = '{1, 16'h0096, 8, 18, 20, 5};
    vt[4] = '{1, 16'h0000, 8, 18, 20, 0};
    vt[5] = '{1, 16'h00FF, 8, 18, 20, 0};
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    repeat (3) tick;
    chk("rst cs", cs_w[0], 1);
    chk("rst sck", sck_w[0], 0);
    chk("rst mosi", mosi_w[0], 0);
    chk("rst ready", aif.tx_ready, 1);
    chk("rst done", aif.done, 0);
    chk("rst busy", aif.busy, 0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) begin
      int d;
      d = vt[i].d;
      n0 = nfr[d];
      dn = ndone[d];
      send(d, vt[i].data, lat);
      chk($sformatf("v%0d frame", i), last_fr[d], vt[i].data);
      chk($sformatf("v%0d rises", i), bits_at[d], vt[i].bits);
      chk($sformatf("v%0d cs_low", i), lo_at[d], vt[i].cs_low);
      chk($sformatf("v%0d ready_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d mosi_toggles", i), tog_at[d], vt[i].tog);
      chk($sformatf("v%0d frames", i), nfr[d] - n0, 1);
      chk($sformatf("v%0d done_pulses", i), ndone[d] - dn, 1);
    end

    n0 = nfr[0];
    drive(0, 1'b1, 16'h0001);
    wait_rdy(0);
    @(posedge clk);
    tick;
    drive(0, 1'b1, 16'h8000);
    wait_rdy(0);
    @(posedge clk);
    tick;
    drive(0, 1'b0, 16'h0);
    n = 0;
    while (nfr[0] < n0 + 2 && n < 1000) begin tick; n++; end
    chk("b2b frames", nfr[0] - n0, 2);
    chk("b2b first", prev_fr[0], 16'h0001);
    chk("b2b second", last_fr[0], 16'h8000);
    chk("b2b cs_high", last_hi[0], 3);
    wait_rdy(0);

    n0 = nfr[0];
    start(0, 16'h1234);
    t0 = cyc;
    repeat (50) tick;
    drive(0, 1'b1, 16'hFFFF);
    chk("ignore busy", aif.busy, 1);
    chk("ignore ready", aif.tx_ready, 0);
    tick;
    drive(0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("ignore ready_lat", cyc - t0 + 1, 135);
    repeat (200) tick;
    chk("ignore frames", nfr[0] - n0, 1);
    chk("ignore frame", last_fr[0], 16'h1234);

    start(0, 16'hC3C3);
    n = 0;
    while (nb[0] < 7 && n < 500) begin tick; n++; end
    dn = ndone[0];
    reset = 1'b1;
    tick;
    chk("abort cs", cs_w[0], 1);
    chk("abort sck", sck_w[0], 0);
    chk("abort mosi", mosi_w[0], 0);
    chk("abort ready", aif.tx_ready, 1);
    chk("abort done", aif.done, 0);
    reset = 1'b0;
    repeat (10) tick;
    chk("abort no_done", ndone[0] - dn, 0);
    chk("abort rises", bits_at[0], 7);
    send(0, 16'h5A5A, lat);
    chk("after_abort frame", last_fr[0], 16'h5A5A);
    chk("after_abort rises", bits_at[0], 16);
    chk("after_abort lat", lat, 135);

    chk("mosi_stable", v_mosi, 0);
    chk("done_on_cs_rise", v_done, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
